// File: rtl/pll_seq_pkg.sv
// Shared types and default NES clock-enable ratios for the PLL reset/clock-enable sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } pll_state_t;

  localparam int unsigned MASTER_DIV_PPU = 4;
  localparam int unsigned MASTER_DIV_CPU = 12;

endpackage

// File: rtl/frac_ce_chan.sv
// One fractional clock-enable channel: NUM pulses every DEN enabled cycles.
module frac_ce_chan #(
  parameter int unsigned ACC_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // DEN < 2^(ACC_W-1) and NUM <= DEN keep this sum from wrapping.
  assign sum = acc + num;

  always_ff @(posedge clock) begin
    if (reset || !run) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (sum >= den) begin
      acc <= sum - den;
      ce  <= 1'b1;
    end else begin
      acc <= sum;
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Holds the system in reset until PLL lock is stable, then emits phase-aligned
// fractional clock-enables and tracks lock losses seen while running.
module pll_reset_ce_gen
  import pll_seq_pkg::*;
#(
  parameter int unsigned              NUM_CH        = 2,
  parameter int unsigned              ACC_W         = 8,
  parameter logic [NUM_CH*ACC_W-1:0]  CE_NUM        = {8'd1, 8'd1},
  parameter logic [NUM_CH*ACC_W-1:0]  CE_DEN        = {8'(MASTER_DIV_CPU), 8'(MASTER_DIV_PPU)},
  parameter int unsigned              STABLE_CYCLES = 16,
  parameter int unsigned              CNT_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  output logic              sys_reset,
  output logic [NUM_CH-1:0] ce,
  output logic              lock_lost,
  output logic [CNT_W-1:0]  loss_count
);

  localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $fatal(1, "pll_reset_ce_gen: NUM_CH must be 1..8");
  end
  if (ACC_W < 2 || ACC_W > 31) begin : g_bad_acc_w
    $fatal(1, "pll_reset_ce_gen: ACC_W must be 2..31");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $fatal(1, "pll_reset_ce_gen: STABLE_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $fatal(1, "pll_reset_ce_gen: CNT_W must be 1..31");
  end

  logic              s1;
  logic              lk;
  pll_state_t        state;
  pll_state_t        state_nxt;
  logic [STAB_W-1:0] stab_cnt;
  logic [STAB_W-1:0] cnt_nxt;
  logic              loss;
  logic              run;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = stab_cnt;
    loss      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lk) begin
          state_nxt = STABILIZE;
          cnt_nxt   = '0;
        end
      end
      STABILIZE: begin
        if (!lk) begin
          state_nxt = WAIT_LOCK;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = stab_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lk) begin
          state_nxt = WAIT_LOCK;
          loss      = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1         <= 1'b0;
      lk         <= 1'b0;
      state      <= WAIT_LOCK;
      stab_cnt   <= '0;
      sys_reset  <= 1'b1;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      s1        <= pll_locked;
      lk        <= s1;
      state     <= state_nxt;
      stab_cnt  <= cnt_nxt;
      sys_reset <= (state_nxt != RUN);
      if (loss) begin
        lock_lost <= 1'b1;
        if (loss_count != '1) loss_count <= loss_count + 1'b1;
      end
    end
  end

  // Channels advance only on edges that stay in RUN, so the edge leaving RUN
  // clears them together with sys_reset rising.
  assign run = (state == RUN) && (state_nxt == RUN);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int unsigned NUM_K = int'(CE_NUM[k*ACC_W +: ACC_W]);
    localparam int unsigned DEN_K = int'(CE_DEN[k*ACC_W +: ACC_W]);

    if (NUM_K < 1 || NUM_K > DEN_K || DEN_K >= (32'd1 << (ACC_W - 1))) begin : g_bad_ratio
      $fatal(1, "pll_reset_ce_gen: channel ratio out of range");
    end

    frac_ce_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .num   (CE_NUM[k*ACC_W +: ACC_W]),
      .den   (CE_DEN[k*ACC_W +: ACC_W]),
      .ce    (ce[k])
    );
  end

endmodule
